// File: rtl/data_ram_pkg.sv
// Shared constants and helpers for the data RAM arbiter slice.
package data_ram_pkg;

  localparam int DATA_RAM_DEPTH  = 4096;
  localparam int DATA_RAM_ADDR_W = 12;
  localparam int DATA_RAM_DATA_W = 32;
  localparam int DATA_RAM_BE_W   = 4;

  // Requester indices are carried in a fixed 3-bit field (up to 8 requesters).
  localparam int MAX_REQ = 8;
  localparam int PTR_W   = 3;

  // Round-robin successor of ptr among n requesters, wrapping to 0.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr, input int n);
    logic [PTR_W-1:0] nxt;
    if (int'(ptr) >= n - 1) begin
      nxt = '0;
    end else begin
      nxt = ptr + PTR_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after start_ptr,
// searching upward with wrap. Produces a one-hot grant and a valid flag.
module rr_priority_pick
  import data_ram_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   start_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  // Walk distances from start_ptr in increasing order; the first hit wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!valid && req[i] && (((i + NUM_REQ - int'(start_ptr)) % NUM_REQ) == k)) begin
          grant[i] = 1'b1;
          valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter sharing one data RAM port between NUM_REQ masters,
// with per-requester lock for atomic read-modify-write and in-order read
// response routing (read latency 1).
module data_ram_arbiter
  import data_ram_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = DATA_RAM_ADDR_W,
  parameter int DATA_W  = DATA_RAM_DATA_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_read,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ-1:0]          req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_byteenable,
  input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
  output logic [NUM_REQ-1:0]          req_waitrequest,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_readdata,
  output logic [ADDR_W-1:0]           ram_address,
  output logic [DATA_W/8-1:0]         ram_byteenable,
  output logic                        ram_chipselect,
  output logic                        ram_write,
  output logic [DATA_W-1:0]           ram_writedata,
  input  logic [DATA_W-1:0]           ram_readdata
);

  localparam int BE_W = DATA_W / 8;

  // Arbitration state
  logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic             locked_reg, locked_next;
  logic [PTR_W-1:0] lock_owner_reg, lock_owner_next;
  logic             rd_pending_reg, rd_pending_next;
  logic [PTR_W-1:0] rd_id_reg, rd_id_next;

  // Per-requester views of the flattened request buses
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [BE_W-1:0]   be_arr   [NUM_REQ];
  logic [DATA_W-1:0] wd_arr   [NUM_REQ];

  logic [NUM_REQ-1:0] active;
  logic [NUM_REQ-1:0] owner_onehot;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [PTR_W-1:0]   start_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_read;
  logic               owner_lock;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]     = req_address[gi*ADDR_W +: ADDR_W];
      assign be_arr[gi]       = req_byteenable[gi*BE_W +: BE_W];
      assign wd_arr[gi]       = req_writedata[gi*DATA_W +: DATA_W];
      assign owner_onehot[gi] = (lock_owner_reg == PTR_W'(gi));
      assign rsp_valid[gi]    = rd_pending_reg && (rd_id_reg == PTR_W'(gi));
    end
  endgenerate

  assign active = req_read | req_write;

  // While locked only the owner may win, and the search starts at the owner.
  assign eligible  = locked_reg ? (active & owner_onehot) : active;
  assign start_ptr = locked_reg ? lock_owner_reg : rr_ptr_reg;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req       (eligible),
    .start_ptr (start_ptr),
    .grant     (grant),
    .valid     (grant_valid)
  );

  assign req_waitrequest = ~grant;
  assign grant_read      = |(grant & req_read);
  assign owner_lock      = |(owner_onehot & req_lock);
  assign rsp_readdata    = rd_pending_reg ? ram_readdata : '0;

  // Encode the one-hot grant into a requester index.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = PTR_W'(i);
      end
    end
  end

  // Drive the RAM port from the granted requester; all zero when idle.
  always_comb begin
    ram_address    = '0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    ram_chipselect = grant_valid;
    ram_write      = |(grant & req_write);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        ram_address    = addr_arr[i];
        ram_byteenable = be_arr[i];
        ram_writedata  = wd_arr[i];
      end
    end
  end

  // Next-state for round-robin pointer, lock and read tracking.
  always_comb begin
    rr_ptr_next     = rr_ptr_reg;
    locked_next     = locked_reg;
    lock_owner_next = lock_owner_reg;
    rd_pending_next = grant_valid && grant_read;
    rd_id_next      = (grant_valid && grant_read) ? grant_idx : rd_id_reg;

    // The pointer only advances on grants made outside a held lock.
    if (grant_valid && !locked_reg) begin
      rr_ptr_next = rr_next(grant_idx, NUM_REQ);
    end

    if (locked_reg) begin
      // Owner dropping its lock request (granted or idle) releases next edge.
      if (!owner_lock) begin
        locked_next = 1'b0;
      end
    end else if (grant_valid && |(grant & req_lock)) begin
      locked_next     = 1'b1;
      lock_owner_next = grant_idx;
    end
  end

  // State registers; reset drops any pending response and releases the lock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg     <= '0;
      locked_reg     <= 1'b0;
      lock_owner_reg <= '0;
      rd_pending_reg <= 1'b0;
      rd_id_reg      <= '0;
    end else begin
      rr_ptr_reg     <= rr_ptr_next;
      locked_reg     <= locked_next;
      lock_owner_reg <= lock_owner_next;
      rd_pending_reg <= rd_pending_next;
      rd_id_reg      <= rd_id_next;
    end
  end

endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Shares one port of the controller's 4096×32 dual-port data RAM between `NUM_REQ` internal masters (sensor capture, motor-control loop, telemetry packer). Each cycle the block grants at most one requester, using round-robin, and drives the RAM port with that requester's access. It returns read data one cycle later to the requester that issued the read. A per-requester lock holds the grant across cycles for atomic read-modify-write sequences.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters (2..8).
- `ADDR_W`, 12: word address width.
- `DATA_W`, 32: data width; byteenable width is `DATA_W/8`.

Ports:
- `clk`  in  1: the single clock for the block.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req_read`  in  NUM_REQ: per-requester read request.
- `req_write`  in  NUM_REQ: per-requester write request. Read and write are mutually exclusive per requester.
- `req_lock`  in  NUM_REQ: requests exclusive grant for the following cycles.
- `req_address`  in  NUM_REQ*ADDR_W: flattened addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- `req_byteenable`  in  NUM_REQ*DATA_W/8: flattened byte enables.
- `req_writedata`  in  NUM_REQ*DATA_W: flattened write data.
- `req_waitrequest`  out  NUM_REQ: high means the request is not accepted this cycle.
- `rsp_valid`  out  NUM_REQ: one-hot; read data is valid for requester i.
- `rsp_readdata`  out  DATA_W: read data shared by all requesters; qualified by `rsp_valid`.
- `ram_address`  out  ADDR_W: address to the RAM port.
- `ram_byteenable`  out  DATA_W/8: byte enables to the RAM port.
- `ram_chipselect`  out  1: chipselect to the RAM port.
- `ram_write`  out  1: write enable to the RAM port.
- `ram_writedata`  out  DATA_W: write data to the RAM port.
- `ram_readdata`  in  DATA_W: RAM read data. The RAM registers the address, its output is unregistered, and read latency is 1.

## Operation
- Active request: requester i is active when `req_read[i] | req_write[i]`.
- Grant, combinational: if the lock is held, only `lock_owner` is eligible. Otherwise the first active requester at or after `rr_ptr`, searching upward with wrap, is granted.
- Granted requester: `req_waitrequest[i]`=0, and its address, byteenable and writedata drive the RAM. `ram_chipselect`=1 and `ram_write`=`req_write[i]`.
- All other requesters: `req_waitrequest`=1. An idle requester also sees waitrequest=1; this is harmless.
- No grant: `ram_chipselect`=0, `ram_write`=0, and the other RAM outputs are held at zero.
- `rr_ptr` update: after a grant to i, `rr_ptr` ← (i+1) mod NUM_REQ. It is unchanged when there is no grant or while the lock is held.
- Lock set: a grant to i with `req_lock[i]`=1 sets `lock_owner`=i and `locked`=1.
- Lock clear: the lock clears on the clock edge after a cycle in which the owner has `req_lock`=0. That cycle is either a final granted access with lock low, or an idle cycle.
- Read tracking: a granted read registers `rd_pending`=1 and `rd_id`=i.
- Read response: in the next cycle `rsp_valid[rd_id]`=1 and `rsp_readdata`=`ram_readdata`. Responses are strictly in order, and back-to-back reads give a response every cycle.
- Write: a granted write produces no response.

## Timing
- Reset values: `rr_ptr`=0, `locked`=0, `lock_owner`=0, `rd_pending`=0. Therefore `rsp_valid`=0 and `rsp_readdata`=0. The RAM outputs are zero while no request is present.
- Reset priority: after reset, requester 0 wins a tie.
- Accept latency: 0 cycles. The request is accepted in the same cycle it is granted.
- Read data latency: exactly 1 cycle after acceptance.
- Throughput: one access per cycle. With all NUM_REQ requesters continuously active, each is granted once every NUM_REQ cycles.
- Held requests: a request held under waitrequest must keep its address and data stable. The arbiter does not latch request fields.
- Reset asserted mid-operation: a pending read response is dropped, with `rsp_valid` forced to 0 asynchronously, and the lock is released.
- Lock owner drops the request entirely while locked: other requesters remain blocked until the owner's `req_lock` is seen low. Requesters must therefore deassert lock when finished.

## Structure
- Package `data_ram_pkg`:
  - Constants: `DATA_RAM_DEPTH`=4096, `DATA_RAM_ADDR_W`=12, `DATA_RAM_DATA_W`=32, `DATA_RAM_BE_W`=4.
  - Function `rr_next(ptr, n)`.
- Sub-module `rr_priority_pick`: purely combinational. Inputs are the `NUM_REQ` request vector and the start pointer. Outputs are a one-hot grant and a valid flag. It is reused for both the locked and the unlocked case; in the locked case its input is masked to the owner.
- Top level holds `rr_ptr`, the lock state, the read-tracking registers and the request-field muxes.

## Test plan
- Single reader: requester 1 reads address 0x005, where the RAM holds 0x1234_5678. Expect waitrequest[1]=0 in the same cycle, and in the next cycle `rsp_valid`=3'b010 with `rsp_readdata`=0x1234_5678.
- Fairness: all three requesters read continuously from reset. Expect the grant order 0,1,2,0,1,2 and a `rsp_valid` one-hot sequence matching that order, delayed by one cycle.
- Byte write: requester 2 writes 0xAABB_CCDD with byteenable 4'b0011 over 0x1111_1111, then reads it back. Expect 0x1111_CCDD.
- Lock: requester 0 reads 0x010 with lock=1, then writes 0x010 with lock=0, while requesters 1 and 2 hold requests. Expect requesters 1 and 2 to see waitrequest=1 for both cycles, then requester 1 is granted.
- Reset mid-read: a read is granted, then `reset_n` goes low before the next edge. Expect `rsp_valid`=0 immediately, with `rr_ptr` and lock at their reset values after release.
